// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared definitions for the FT2232H Tx arbiter: FSM state encoding,
// frame header tag and the header builder.
package ftdi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHKSUM  = 2'd3
    } state_e;

    localparam logic [3:0] HDR_TAG = 4'hA;

    // Header byte carries the tag in the high nibble and the source id in the low nibble.
    function automatic logic [7:0] build_header(input logic [3:0] src_id);
        return {HDR_TAG, src_id};
    endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping from NUM_SRC-1 back to 0. The pointer register lives in the caller.
module rr_arbiter
    import ftdi_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [3:0]         ptr_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [3:0]         id_o,
    output logic               valid_o
);

    // Two passes: requesters at/after the pointer first, then the wrapped ones below it.
    always_comb begin
        gnt_o   = '0;
        id_o    = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                id_o     = 4'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!valid_o && req_i[i]) begin
                valid_o  = 1'b1;
                gnt_o[i] = 1'b1;
                id_o     = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the FT2232H Tx FIFO.
// Frame: header {A, src_id}, payload (cut at MAX_LEN), optional XOR checksum.
// Optional feature macro: FTDI_TX_CHKSUM_EN adds the trailing checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet; pick next source round-robin when enabled
// HEADER  | write {A, gnt_id}; stall while FIFO full
// PAYLOAD | forward granted source bytes until last or MAX_LEN
// CHKSUM  | write XOR of header and payload (checksum build only)
module ftdi_tx_arbiter
    import ftdi_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int MAX_LEN = 64
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iEn,
    input  logic [NUM_SRC-1:0]     iSrcValid,
    input  logic [8*NUM_SRC-1:0]   iSrcData,
    input  logic [NUM_SRC-1:0]     iSrcLast,
    output logic [NUM_SRC-1:0]     oSrcReady,
    output logic                   oTxWrEn,
    output logic [7:0]             oTxData,
    input  logic                   iTxWrFull,
    output logic                   oBusy,
    output logic [3:0]             oGntId,
    output logic                   oTrunc
);

    localparam int         CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [4:0] LAST_ID = 5'(NUM_SRC - 1);

    state_e               state_q, state_d;
    logic [3:0]           ptr_q, ptr_d;
    logic [3:0]           gnt_id_q, gnt_id_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 trunc_q, trunc_d;
`ifdef FTDI_TX_CHKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    logic [NUM_SRC-1:0]   arb_gnt;
    logic [3:0]           arb_id;
    logic                 arb_valid;

    logic [7:0]           sel_data;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 byte_wr;
    logic                 at_max;
    logic [3:0]           ptr_next;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req_i   (iSrcValid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .id_o    (arb_id),
        .valid_o (arb_valid)
    );

    // Mux the granted source's byte, valid and last using the latched one-hot grant.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_q[i]) begin
                sel_data  = iSrcData[8*i +: 8];
                sel_valid = iSrcValid[i];
                sel_last  = iSrcLast[i];
            end
        end
    end

    assign byte_wr  = (state_q == ST_PAYLOAD) && sel_valid && !iTxWrFull;
    assign at_max   = (cnt_q == CNT_W'(MAX_LEN - 1));
    assign ptr_next = ({1'b0, gnt_id_q} == LAST_ID) ? 4'd0 : gnt_id_q + 4'd1;

    // Next-state and FIFO/handshake outputs; every output defaults to idle values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_id_d  = gnt_id_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        trunc_d   = 1'b0;
`ifdef FTDI_TX_CHKSUM_EN
        chk_d     = chk_q;
`endif
        oSrcReady = '0;
        oTxWrEn   = 1'b0;
        oTxData   = '0;

        case (state_q)
            ST_IDLE: begin
                if (iEn && arb_valid) begin
                    gnt_d    = arb_gnt;
                    gnt_id_d = arb_id;
                    cnt_d    = '0;
                    state_d  = ST_HEADER;
                end
            end
            ST_HEADER: begin
                oTxData = build_header(gnt_id_q);
                oTxWrEn = !iTxWrFull;
                if (!iTxWrFull) begin
`ifdef FTDI_TX_CHKSUM_EN
                    chk_d = build_header(gnt_id_q);
`endif
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                oSrcReady = iTxWrFull ? '0 : gnt_q;
                oTxData   = sel_data;
                oTxWrEn   = byte_wr;
                if (byte_wr) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef FTDI_TX_CHKSUM_EN
                    chk_d = chk_q ^ sel_data;
`endif
                    if (sel_last || at_max) begin
                        // A last marker on the final allowed byte is a normal end, not a cut.
                        trunc_d = !sel_last;
                        ptr_d   = ptr_next;
`ifdef FTDI_TX_CHKSUM_EN
                        state_d = ST_CHKSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_CHKSUM: begin
`ifdef FTDI_TX_CHKSUM_EN
                oTxData = chk_q;
                oTxWrEn = !iTxWrFull;
                if (!iTxWrFull) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            trunc_q  <= 1'b0;
`ifdef FTDI_TX_CHKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            trunc_q  <= trunc_d;
`ifdef FTDI_TX_CHKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign oBusy  = (state_q != ST_IDLE);
    assign oGntId = gnt_id_q;
    assign oTrunc = trunc_q;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Scoreboard bench for ftdi_tx_arbiter: sources replay byte streams, a packet-level
// model predicts the FIFO byte sequence, a monitor pops and compares every write.
module tb_ftdi_tx_arbiter;

    localparam int N     = 3;
    localparam int MAXL  = 64;
    localparam int DEPTH = 1024;
`ifdef FTDI_TX_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last  = '0;
    logic [8*N-1:0] data  = '0;
    logic           full  = 1'b0;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [7:0]     tx_data;
    logic           busy;
    logic [3:0]     gnt_id;
    logic           trunc;

    always #10 clk = ~clk;

    ftdi_tx_arbiter #(
        .NUM_SRC (N),
        .MAX_LEN (MAXL)
    ) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iEn       (en),
        .iSrcValid (valid),
        .iSrcData  (data),
        .iSrcLast  (last),
        .oSrcReady (ready),
        .oTxWrEn   (wr_en),
        .oTxData   (tx_data),
        .iTxWrFull (full),
        .oBusy     (busy),
        .oGntId    (gnt_id),
        .oTrunc    (trunc)
    );

    // committed source streams (driver side)
    logic [7:0] sdat [N][DEPTH];
    bit         slst [N][DEPTH];
    bit         sfst [N][DEPTH];
    int         slen [N];
    int         spos [N];
    // staged bytes for the next phase
    logic [7:0] stg_d [N][256];
    bit         stg_l [N][256];
    bit         stg_f [N][256];
    int         stg_n [N];

    logic [7:0] expq[$];
    logic [7:0] mon_e;
    int  total = 0, bad = 0;
    int  exp_trunc = 0, got_trunc = 0, wr_cnt = 0;
    int  mptr = 0;
    bit  acc [N];
    bit  gap_en = 0, full_rand = 0, full_force = 0, flush_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record handshakes and score every FIFO write.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < N; s++) acc[s] = 1'b0;
        end else begin
            for (int s = 0; s < N; s++) acc[s] = valid[s] & ready[s];
            if (trunc) got_trunc++;
            if (wr_en) begin
                wr_cnt++;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h expected no write", tx_data);
                end else begin
                    mon_e = expq.pop_front();
                    check("fifo_byte", {24'h0, tx_data}, {24'h0, mon_e});
                end
            end
        end
    end

    // Source drivers: first byte of each packet is held valid, later bytes may gap.
    always @(posedge clk) begin
        #1;
        for (int s = 0; s < N; s++) begin
            if (acc[s]) spos[s]++;
            if (flush_req) spos[s] = slen[s];
            if (spos[s] < slen[s]) begin
                data[8*s +: 8] = sdat[s][spos[s]];
                last[s]        = slst[s][spos[s]];
                valid[s]       = sfst[s][spos[s]] || !gap_en || ($urandom_range(3) != 0);
            end else begin
                data[8*s +: 8] = 8'h00;
                last[s]        = 1'b0;
                valid[s]       = 1'b0;
            end
        end
        full = full_force || (full_rand && ($urandom_range(3) == 0));
    end

    task automatic add_byte(input int s, input logic [7:0] d, input bit l);
        stg_d[s][stg_n[s]] = d;
        stg_l[s][stg_n[s]] = l;
        stg_n[s]++;
    endtask

    task automatic add_pkt(input int s, input int len, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++)
            add_byte(s, rnd ? 8'($urandom_range(255)) : base + 8'(i), i == len - 1);
    endtask

    // Packet-level model: split staged streams into packets, serve round-robin,
    // push the expected frames, then hand the streams to the drivers.
    task automatic launch();
        int idx [N];
        int found, s, n;
        bit done;
        logic [7:0] hdr, chk, b;
        for (int k = 0; k < N; k++) begin
            idx[k] = 0;
            for (int i = 0; i < stg_n[k]; i++) stg_f[k][i] = 1'b0;
        end
        while (1) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (found < 0 && idx[c] < stg_n[c]) found = c;
            end
            if (found < 0) break;
            s   = found;
            hdr = {4'hA, 4'(s)};
            expq.push_back(hdr);
            chk = hdr;
            n = 0;
            done = 1'b0;
            stg_f[s][idx[s]] = 1'b1;
            while (!done && idx[s] < stg_n[s]) begin
                b = stg_d[s][idx[s]];
                expq.push_back(b);
                chk = chk ^ b;
                n++;
                done = stg_l[s][idx[s]];
                idx[s]++;
                if (n == MAXL && !done) begin
                    exp_trunc++;
                    done = 1'b1;
                end
            end
            if (CHK != 0) expq.push_back(chk);
            mptr = (s + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < stg_n[k]; i++) begin
                sdat[k][slen[k] + i] = stg_d[k][i];
                slst[k][slen[k] + i] = stg_l[k][i];
                sfst[k][slen[k] + i] = stg_f[k][i];
            end
            slen[k] += stg_n[k];
            stg_n[k] = 0;
        end
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while ((expq.size() != 0 || busy) && c < 4000) begin
            @(negedge clk); #1;
            c++;
        end
        check({name, "_drained"}, expq.size(), 0);
        check({name, "_trunc"}, got_trunc, exp_trunc);
    endtask

    task automatic wait_wr(input string name, input int target);
        int c;
        c = 0;
        while (wr_cnt < target && c < 500) begin
            @(negedge clk); #1;
            c++;
        end
        check(name, {31'h0, wr_cnt >= target}, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, {29'h0, ready}, 0);
        check({tag, "_wren"},  {31'h0, wr_en}, 0);
        check({tag, "_data"},  {24'h0, tx_data}, 0);
        check({tag, "_busy"},  {31'h0, busy}, 0);
        check({tag, "_gntid"}, {28'h0, gnt_id}, 0);
        check({tag, "_trunc"}, {31'h0, trunc}, 0);
    endtask

    initial begin
        int base, snap, c;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // 1: single 3-byte packet, header one cycle after valid
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        @(negedge clk); #1;
        launch();
        @(negedge clk); #1;
        check("t1_idle_no_write", {31'h0, wr_en}, 0);
        @(negedge clk); #1;
        check("t1_hdr_wren", {31'h0, wr_en}, 1);
        check("t1_hdr_byte", {24'h0, tx_data}, 32'hA0);
        wait_done("t1");

        // 2: two sources contending, no interleaving
        add_pkt(0, 2, 1'b0, 8'h20);
        add_pkt(0, 2, 1'b0, 8'h24);
        add_pkt(1, 2, 1'b0, 8'h30);
        @(negedge clk); #1;
        launch();
        wait_done("t2");

        // 3: FIFO full for 5 cycles mid-payload
        base = wr_cnt;
        add_pkt(0, 6, 1'b0, 8'h40);
        @(negedge clk); #1;
        launch();
        wait_wr("t3_reach_payload", base + 3);
        full_force = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("t3_stall_wren",  {31'h0, wr_en}, 0);
            check("t3_stall_ready", {29'h0, ready}, 0);
        end
        full_force = 1'b0;
        wait_done("t3");

        // 4: 70-byte stream cut at MAX_LEN, remainder as a new packet
        add_pkt(1, 70, 1'b0, 8'h01);
        @(negedge clk); #1;
        launch();
        wait_done("t4");
        check("t4_trunc_count", got_trunc, 1);

        // 5: enable dropped after header
        base = wr_cnt;
        add_pkt(0, 4, 1'b0, 8'h50);
        add_pkt(1, 4, 1'b0, 8'h60);
        @(negedge clk); #1;
        launch();
        wait_wr("t5_header_seen", base + 1);
        en = 1'b0;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk); #1;
            c++;
        end
        check("t5_busy_fall", {31'h0, busy}, 0);
        snap = wr_cnt;
        repeat (10) begin
            @(negedge clk); #1;
        end
        check("t5_no_hdr_while_dis", wr_cnt, snap);
        check("t5_pending_frame", expq.size(), 1 + 4 + CHK);
        en = 1'b1;
        wait_done("t5");

        // 6: reset mid-payload
        base = wr_cnt;
        add_pkt(1, 10, 1'b0, 8'h70);
        @(negedge clk); #1;
        launch();
        wait_wr("t6_reach_payload", base + 4);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_rst");
        expq.delete();
        flush_req = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        flush_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        #1;
        check("t6_busy_after", {31'h0, busy}, 0);
        base = wr_cnt;
        add_pkt(1, 3, 1'b0, 8'h80);
        add_pkt(0, 2, 1'b0, 8'h90);
        @(negedge clk); #1;
        launch();
        wait_wr("t6_first_write", base + 1);
        check("t6_first_grant", {28'h0, gnt_id}, 0);
        wait_done("t6");

        // randomized phases with gaps and random FIFO back-pressure
        gap_en    = 1'b1;
        full_rand = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int s = 0; s < N; s++) begin
                int npk;
                npk = $urandom_range(3);
                for (int k = 0; k < npk; k++) begin
                    if ($urandom_range(9) == 0)
                        add_pkt(s, $urandom_range(70, 66), 1'b1, 8'h00);
                    else
                        add_pkt(s, $urandom_range(8, 1), 1'b1, 8'h00);
                end
            end
            @(negedge clk); #1;
            launch();
            wait_done("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout: simulation did not finish, bad so far %0d", bad);
        $fatal(1);
    end

endmodule
